// File: rtl/avl_rr_arbiter.sv
// avl_rr_arbiter: N-way round-robin Avalon-MM arbiter with per-transaction grant lock and stall watchdog
module avl_rr_arbiter #(
  parameter int N       = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           m_read,
  input  logic [N-1:0]           m_write,
  input  logic [N*32-1:0]        m_address,
  input  logic [N*32-1:0]        m_writedata,
  input  logic [N*4-1:0]         m_byteenable,
  output logic [31:0]            m_readdata,
  output logic [N-1:0]           m_waitrequest,
  output logic [31:0]            avl_address,
  output logic [31:0]            avl_writedata,
  output logic [3:0]             avl_byteenable,
  output logic                   avl_read,
  output logic                   avl_write,
  input  logic [31:0]            avl_readdata,
  input  logic                   avl_waitrequest,
  output logic [$clog2(N)-1:0]   grant,
  output logic                   timeout_err
);
  localparam int GW = $clog2(N);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] last_q, last_d, grant_q, grant_d, sel, mux;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic [N-1:0] req;
  logic any_req, busy, active, abort;
  assign req     = m_read | m_write;
  assign any_req = |req;
  assign busy    = state_q == BUSY;
  assign active  = busy || any_req;
  always_comb begin
    sel = last_q;
    for (int k = N; k >= 1; k--)
      if (req[(int'(last_q) + k) % N]) sel = GW'((int'(last_q) + k) % N);
  end
  // the idle bus still presents the last owner's signals so the mux never glitches to a random requester
  assign mux   = busy ? grant_q : (any_req ? sel : last_q);
  assign abort = busy && TIMEOUT > 0 && avl_waitrequest && int'(cnt_q) >= TIMEOUT - 1;
  assign avl_address    = m_address[32*mux +: 32];
  assign avl_writedata  = m_writedata[32*mux +: 32];
  assign avl_byteenable = m_byteenable[4*mux +: 4];
  assign avl_write      = active && !abort && m_write[mux];
  assign avl_read       = active && !abort && m_read[mux] && !m_write[mux];
  assign m_readdata     = avl_readdata;
  assign grant          = (!busy && any_req) ? sel : grant_q;
  assign timeout_err    = err_q;
  always_comb begin
    m_waitrequest = '1;
    if (active) m_waitrequest[mux] = abort ? 1'b0 : avl_waitrequest;
  end
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (!busy) begin
      if (any_req) begin
        grant_d = sel;
        if (avl_waitrequest) begin
          state_d = BUSY;
          cnt_d   = CW'(1);
        end else last_d = sel;
      end
    end else if (abort || !avl_waitrequest) begin
      err_d   = err_q | abort;
      last_d  = grant_q;
      cnt_d   = '0;
      state_d = IDLE;
    end else cnt_d = cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= GW'(N - 1);
      grant_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_avl_rr_arbiter.sv
// tb_avl_rr_arbiter: directed and randomized checks of avl_rr_arbiter against a behavioural model
module tb_avl_rr_arbiter;
  localparam int N  = 3;
  localparam int TO = 8;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [N-1:0] m_read = '0, m_write = '0;
  logic [N*32-1:0] m_address = '0, m_writedata = '0;
  logic [N*4-1:0] m_byteenable = '0;
  logic [31:0] m_readdata, avl_address, avl_writedata, avl_readdata = '0;
  logic [N-1:0] m_waitrequest;
  logic [3:0] avl_byteenable;
  logic avl_read, avl_write, avl_waitrequest = 0, timeout_err;
  logic [$clog2(N)-1:0] grant;
  avl_rr_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .m_read(m_read), .m_write(m_write), .m_address(m_address),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_readdata(m_readdata),
    .m_waitrequest(m_waitrequest), .avl_address(avl_address), .avl_writedata(avl_writedata),
    .avl_byteenable(avl_byteenable), .avl_read(avl_read), .avl_write(avl_write),
    .avl_readdata(avl_readdata), .avl_waitrequest(avl_waitrequest), .grant(grant),
    .timeout_err(timeout_err)
  );
  bit busy, err, chk_en;
  int owner, last = N - 1, stalls, gnt, n_vec, n_err;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_step;
    int win, cur, idx;
    bit ab;
    logic [N-1:0] rq, ew;
    rq = m_read | m_write;
    win = -1;
    if (!busy)
      for (int k = 1; k <= N; k++)
        if (win < 0 && rq[(last + k) % N]) win = (last + k) % N;
    cur = busy ? owner : win;
    idx = cur >= 0 ? cur : last;
    ab = busy && avl_waitrequest && stalls + 1 >= TO;
    ew = '1;
    if (cur >= 0) ew[cur] = ab ? 1'b0 : avl_waitrequest;
    if (chk_en) begin
      chk("avl_read", avl_read, cur >= 0 && !ab && m_read[idx] && !m_write[idx]);
      chk("avl_write", avl_write, cur >= 0 && !ab && m_write[idx]);
      chk("avl_address", avl_address, m_address[32*idx +: 32]);
      chk("avl_writedata", avl_writedata, m_writedata[32*idx +: 32]);
      chk("avl_byteenable", avl_byteenable, m_byteenable[4*idx +: 4]);
      chk("m_waitrequest", m_waitrequest, ew);
      chk("m_readdata", m_readdata, avl_readdata);
      chk("grant", grant, (!busy && win >= 0) ? win : gnt);
      chk("timeout_err", timeout_err, err);
    end
    if (rst) begin
      busy = 0; last = N - 1; gnt = 0; err = 0; stalls = 0; chk_en = 1;
    end else if (!busy) begin
      if (win >= 0) begin
        gnt = win;
        if (avl_waitrequest) begin busy = 1; owner = win; stalls = 1; end
        else last = win;
      end
    end else if (ab || !avl_waitrequest) begin
      err |= ab; last = owner; busy = 0; stalls = 0;
    end else stalls++;
  endtask
  task automatic clk_in; @(negedge clk); model_step(); endtask
  task automatic nxt; @(posedge clk); #1; endtask
  task automatic clear; m_read = '0; m_write = '0; avl_waitrequest = 0; endtask
  task automatic do_reset; clear(); rst = 1; clk_in(); nxt(); rst = 0; endtask
  initial begin
    do_reset();
    clk_in();
    chk("s1_read", avl_read, 0);
    chk("s1_write", avl_write, 0);
    chk("s1_mwait", m_waitrequest, 3'b111);
    chk("s1_grant", grant, 0);
    chk("s1_err", timeout_err, 0);
    nxt();
    m_read[1] = 1; m_address[63:32] = 32'h100; avl_readdata = 32'hCAFEF00D;
    clk_in();
    chk("s2_addr", avl_address, 32'h100);
    chk("s2_read", avl_read, 1);
    chk("s2_mwait", m_waitrequest, 3'b101);
    chk("s2_rdata", m_readdata, 32'hCAFEF00D);
    chk("s2_grant", grant, 1);
    nxt();
    do_reset();
    m_read = '1;
    for (int c = 0; c < 6; c++) begin
      clk_in(); chk("s3_grant", grant, c % N); nxt();
    end
    do_reset();
    m_write[2] = 1; m_address[95:64] = 32'h200; m_writedata[95:64] = 32'hA5A5A5A5;
    m_byteenable[11:8] = 4'b0011; avl_waitrequest = 1;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) m_read[0] = 1;
      if (c == 5) avl_waitrequest = 0;
      clk_in();
      chk("s4_grant", grant, 2);
      chk("s4_wdata", avl_writedata, 32'hA5A5A5A5);
      chk("s4_be", avl_byteenable, 4'b0011);
      chk("s4_write", avl_write, 1);
      nxt();
    end
    m_write[2] = 0;
    clk_in(); chk("s4_next_grant", grant, 0); chk("s4_next_read", avl_read, 1); nxt();
    do_reset();
    m_read[0] = 1; avl_waitrequest = 1;
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) m_read[1] = 1;
      clk_in();
      chk("s5_mwait0", m_waitrequest[0], c < 8);
      chk("s5_read", avl_read, c < 8);
      chk("s5_err", timeout_err, 0);
      nxt();
    end
    m_read[0] = 0;
    clk_in(); chk("s5_grant1", grant, 1); chk("s5_err_sticky", timeout_err, 1); nxt();
    avl_waitrequest = 0;
    clk_in(); nxt();
    do_reset();
    m_write[1] = 1; avl_waitrequest = 1;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) rst = 1;
      clk_in(); nxt();
    end
    rst = 0; clear();
    clk_in();
    chk("s6_write", avl_write, 0);
    chk("s6_grant", grant, 0);
    chk("s6_mwait", m_waitrequest, 3'b111);
    nxt();
    m_write = '1;
    clk_in(); chk("s6_first", grant, 0); nxt();
    clear();
    for (int c = 0; c < 3000; c++) begin
      m_read = N'($urandom);
      m_write = N'($urandom & $urandom);
      for (int i = 0; i < N; i++) begin
        m_address[32*i +: 32] = $urandom;
        m_writedata[32*i +: 32] = $urandom;
        m_byteenable[4*i +: 4] = 4'($urandom);
      end
      avl_readdata = $urandom;
      avl_waitrequest = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 299) == 0;
      clk_in(); nxt();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
